k12a_rom_reader: RTL and testbench

Synchronous read controller for the 28256-class asynchronous 32 KiB EEPROM. Accepts single-byte read requests over a valid/ready handshake, drives the ROM's address, chip-enable and output-enable pins with a programmable access window, samples the data bus, and returns the byte over a second valid/ready handshake. Sits between the CPU fetch/load path and the ROM pins; the block never drives the ROM data bus.

---
 rtl/k12a_rom_reader_pkg.sv | 18 +
 rtl/k12a_rom_reader.sv | 99 +++++++++
 tb/tb_k12a_rom_reader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/k12a_rom_reader_pkg.sv
// Shared types and ROM geometry for the k12a ROM read controller.
package k12a_rom_reader_pkg;

  localparam int ROM_ADDR_W = 15;
  localparam int ROM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    TURN
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/k12a_rom_reader.sv
// Read controller for a 28256-class asynchronous EEPROM: handshaked byte reads
// with a programmable CE/OE access window and bus turnaround gap.
module k12a_rom_reader
  import k12a_rom_reader_pkg::*;
#(
  parameter int ACCESS_CYCLES = 4,
  parameter int TURN_CYCLES   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ROM_ADDR_W-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ROM_DATA_W-1:0] rsp_data,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [ROM_DATA_W-1:0] rom_data,
  output logic                  rom_ce_n,
  output logic                  rom_oe_n,
  output logic                  busy,
  output state_t                state
);

  localparam int CNT_W     = $clog2(max_int(ACCESS_CYCLES, TURN_CYCLES) + 1);
  localparam int ACC_LOAD  = ACCESS_CYCLES - 1;
  localparam int TURN_LOAD = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;

  if (ACCESS_CYCLES < 1) begin : g_bad_access
    $error("k12a_rom_reader: ACCESS_CYCLES must be at least 1");
  end
  if (TURN_CYCLES < 0) begin : g_bad_turn
    $error("k12a_rom_reader: TURN_CYCLES must not be negative");
  end

  logic [CNT_W-1:0] count;

  // Both handshakes: a transfer happens at a rising edge where valid and ready
  // are both high; valid and its payload stay stable until that edge, and the
  // request side is only sampled in IDLE (nothing is latched while busy).
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rom_addr  <= '0;
      rom_ce_n  <= 1'b1;
      rom_oe_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rom_addr <= req_addr;
            count    <= CNT_W'(ACC_LOAD);
            rom_ce_n <= 1'b0;
            rom_oe_n <= 1'b0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            // Sample on the last edge of the window, then release the bus.
            rsp_data  <= rom_data;
            rsp_valid <= 1'b1;
            rom_ce_n  <= 1'b1;
            rom_oe_n  <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (TURN_CYCLES > 0) begin
              count <= CNT_W'(TURN_LOAD);
              state <= TURN;
            end else begin
              state <= IDLE;
            end
          end
        end
        TURN: begin
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_k12a_rom_reader.sv
// Bench for k12a_rom_reader: four parameter configurations, each driven by its
// own directed-then-random stimulus and checked against a timestamp model.
module tb_k12a_rom_reader;
  import k12a_rom_reader_pkg::*;

  localparam int NCFG = 4;
  localparam int CFG_A[NCFG]      = '{4, 4, 4, 1};
  localparam int CFG_T[NCFG]      = '{1, 0, 2, 1};
  // Hand-derived: CE/OE low cycles, turnaround idle cycles, request period.
  localparam int EXP_ACC[NCFG]    = '{4, 4, 4, 1};
  localparam int EXP_TURN[NCFG]   = '{1, 0, 2, 1};
  localparam int EXP_PERIOD[NCFG] = '{7, 6, 8, 4};

  // Clock / reset block
  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ROM contents: one fixed byte at 0x1234, a simple hash elsewhere.
  function automatic logic [7:0] rom_byte(input logic [14:0] a);
    if (a == 15'h1234) return 8'hA5;
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int IDX = g;
    localparam int A   = CFG_A[g];
    localparam int T   = CFG_T[g];

    logic        reset, req_valid, req_ready, rsp_valid, rsp_ready;
    logic        rom_ce_n, rom_oe_n, busy;
    logic [14:0] req_addr, rom_addr;
    logic [7:0]  rsp_data, rom_data;
    state_t      state;
    bit          fin = 1'b0;

    k12a_rom_reader #(.ACCESS_CYCLES(A), .TURN_CYCLES(T)) u_dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
      .busy(busy), .state(state)
    );

    // ROM drives valid data only while both enables are low.
    assign rom_data = (!rom_ce_n && !rom_oe_n) ? rom_byte(rom_addr) : 8'hEE;

    // Behavioural model: one transaction described by its accept and handshake times.
    bit          armed = 1'b0;
    bit          have = 1'b0, hs = 1'b0;
    int          n = 0, t_acc = 0, t_hs = 0;
    logic [14:0] m_addr = '0;
    logic [7:0]  m_data = '0;
    bit          m_ready = 1'b1, m_valid = 1'b0, m_ce_low = 1'b0;
    logic [7:0]  exp_q[$];

    initial begin
      forever begin
        @(posedge clock);
        n++;
        if (reset) begin
          armed  = 1'b1;
          have   = 1'b0;
          hs     = 1'b0;
          m_addr = '0;
          m_data = '0;
          exp_q.delete();
        end else if (armed) begin
          if (m_ready && req_valid) begin
            have   = 1'b1;
            hs     = 1'b0;
            t_acc  = n;
            m_addr = req_addr;
            exp_q.push_back(rom_byte(req_addr));
          end else if (m_valid && rsp_ready) begin
            hs   = 1'b1;
            t_hs = n;
          end
          if (have && !hs && n == t_acc + A) m_data = rom_byte(m_addr);
        end
        m_ce_low = have && (n < t_acc + A);
        m_valid  = have && !hs && (n >= t_acc + A);
        m_ready  = !have || (hs && n >= t_hs + T);
      end
    end

    // Compare process: every output on every cycle, plus the response scoreboard.
    initial begin
      forever begin
        @(negedge clock);
        if (armed) begin
          check($sformatf("c%0d_req_ready", IDX), req_ready, m_ready);
          check($sformatf("c%0d_busy", IDX), busy, !m_ready);
          check($sformatf("c%0d_rsp_valid", IDX), rsp_valid, m_valid);
          check($sformatf("c%0d_rsp_data", IDX), rsp_data, m_data);
          check($sformatf("c%0d_rom_addr", IDX), rom_addr, m_addr);
          check($sformatf("c%0d_rom_ce_n", IDX), rom_ce_n, !m_ce_low);
          check($sformatf("c%0d_rom_oe_n", IDX), rom_oe_n, !m_ce_low);
          if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL c%0d_scoreboard: got response %0h expected none", IDX, rsp_data);
            end else begin
              check($sformatf("c%0d_scoreboard", IDX), rsp_data, exp_q.pop_front());
            end
          end
        end
      end
    end

    // Driver tasks
    task automatic step();
      @(posedge clock);
      #1;
    endtask

    task automatic wait_ready(input string what);
      bit got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
        @(negedge clock);
        if (req_ready) got = 1'b1;
      end
      check($sformatf("c%0d_%s_ready_timeout", IDX, what), 32'(got), 1);
    endtask

    task automatic wait_rsp(input string what);
      bit got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
        @(negedge clock);
        if (rsp_valid) got = 1'b1;
      end
      check($sformatf("c%0d_%s_rsp_timeout", IDX, what), 32'(got), 1);
    endtask

    initial begin
      int ce_cnt, lat, turn_cnt, na;
      int acc[2];
      bit got;

      reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
      repeat (3) step();
      @(negedge clock);
      check($sformatf("c%0d_rst_ce_n", IDX), rom_ce_n, 1);
      check($sformatf("c%0d_rst_oe_n", IDX), rom_oe_n, 1);
      check($sformatf("c%0d_rst_req_ready", IDX), req_ready, 1);
      check($sformatf("c%0d_rst_rsp_valid", IDX), rsp_valid, 0);
      check($sformatf("c%0d_rst_rsp_data", IDX), rsp_data, 8'h00);
      check($sformatf("c%0d_rst_busy", IDX), busy, 0);

      // Single read of 0x1234, released with req_valid already high.
      step();
      reset = 1'b0; req_valid = 1'b1; req_addr = 15'h1234;
      wait_ready("single");
      step();
      req_valid = 1'b0;
      ce_cnt = 0; lat = 0; got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clock);
        if (rsp_valid) got = 1'b1;
        else begin
          lat++;
          if (!rom_ce_n && !rom_oe_n) ce_cnt++;
          check($sformatf("c%0d_addr_window", IDX), rom_addr, 15'h1234);
        end
      end
      check($sformatf("c%0d_single_rsp", IDX), 32'(got), 1);
      check($sformatf("c%0d_ce_low_cycles", IDX), ce_cnt, EXP_ACC[IDX]);
      check($sformatf("c%0d_latency", IDX), lat, EXP_ACC[IDX]);
      check($sformatf("c%0d_single_data", IDX), rsp_data, 8'hA5);

      // Backpressure with a competing request held high.
      step();
      req_valid = 1'b1; req_addr = 15'h0555;
      repeat (10) begin
        @(negedge clock);
        check($sformatf("c%0d_bp_valid", IDX), rsp_valid, 1);
        check($sformatf("c%0d_bp_data", IDX), rsp_data, 8'hA5);
        check($sformatf("c%0d_bp_ready", IDX), req_ready, 0);
        check($sformatf("c%0d_bp_ce_n", IDX), rom_ce_n, 1);
      end
      step();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      turn_cnt = 0; got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clock);
        if (req_ready) got = 1'b1;
        else turn_cnt++;
      end
      check($sformatf("c%0d_turn_done", IDX), 32'(got), 1);
      check($sformatf("c%0d_turn_cycles", IDX), turn_cnt, EXP_TURN[IDX]);
      step();
      req_valid = 1'b0; rsp_ready = 1'b1;
      wait_ready("drain");

      // Back-to-back reads with rsp_ready tied high.
      step();
      req_valid = 1'b1; req_addr = 15'h0000;
      na = 0; acc[0] = 0; acc[1] = 0;
      for (int k = 0; k < 60 && na < 2; k++) begin
        @(negedge clock);
        if (req_ready) begin
          acc[na] = k;
          na++;
          @(posedge clock);
          #1;
          if (na == 1) req_addr = 15'h7FFF;
          else req_valid = 1'b0;
        end
      end
      check($sformatf("c%0d_b2b_accepts", IDX), na, 2);
      check($sformatf("c%0d_b2b_period", IDX), acc[1] - acc[0], EXP_PERIOD[IDX]);
      wait_ready("b2b");

      // Reset two edges into an access.
      step();
      req_valid = 1'b1; req_addr = 15'h2A2A;
      wait_ready("mid");
      step();
      req_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clock);
      check($sformatf("c%0d_mid_ce_n", IDX), rom_ce_n, 1);
      check($sformatf("c%0d_mid_oe_n", IDX), rom_oe_n, 1);
      repeat (A + 3) begin
        @(negedge clock);
        check($sformatf("c%0d_mid_no_rsp", IDX), rsp_valid, 0);
      end
      step();
      req_valid = 1'b1; req_addr = 15'h1234;
      wait_ready("post");
      step();
      req_valid = 1'b0;
      wait_rsp("post");
      check($sformatf("c%0d_post_data", IDX), rsp_data, 8'hA5);

      // Random traffic with occasional resets.
      for (int k = 0; k < 400; k++) begin
        step();
        req_valid = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) req_addr = 15'($urandom);
        rsp_ready = ($urandom_range(0, 3) != 0);
        reset = ($urandom_range(0, 149) == 0);
      end
      step();
      reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      repeat (20) step();
      fin = 1'b1;
    end
  end

  // Final report
  initial begin
    wait (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin);
    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
